// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: receiver FSM state encoding, frame
//                constants and the cycles-per-bit helper used by both the
//                receiver and the transmitter.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Frame format: 8 data bits, no parity, one stop bit
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Receiver FSM states, explicit 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_rx_state_t;

  // Number of system clock cycles that make up one bit on the line
  function automatic int cycles_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchronizer for a single asynchronous bit.
//  Ports       : clk   - destination clock
//                rst_n - asynchronous active-low reset
//                d     - asynchronous input
//                q     - synchronized output (two clk cycles of latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  // Both stages reset to RESET_VAL so reset release never looks like an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : uart_receiver
//  Description : 8N1 UART receiver, LSB first. Received bytes are offered on a
//                ready/valid interface backed by a one-entry holding register.
//                Framing errors and overruns are one-cycle pulses.
//  Ports       : clk            - system clock, rising edge
//                rst_n          - asynchronous active-low reset
//                serial_in      - asynchronous serial line, idles high
//                data_out       - received byte, valid while data_out_valid
//                data_out_valid - holding register full
//                data_out_ready - consumer accepts (fire = valid & ready)
//                framing_error  - pulse: stop bit sampled low
//                overrun        - pulse: byte completed while holding reg full
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       framing_error,
  output logic       overrun
);

  localparam int SYMBOL_EDGE_TIME = cycles_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int CNT_WIDTH        = $clog2(SYMBOL_EDGE_TIME) + 1;
  localparam int IDX_WIDTH        = $clog2(DATA_BITS);

  localparam logic [CNT_WIDTH-1:0] C_SAMPLE_LAST = CNT_WIDTH'(SAMPLE_TIME - 1);
  localparam logic [CNT_WIDTH-1:0] C_SYMBOL_LAST = CNT_WIDTH'(SYMBOL_EDGE_TIME - 1);
  localparam logic [IDX_WIDTH-1:0] C_IDX_LAST    = IDX_WIDTH'(DATA_BITS - 1);

  // The mid-bit sampling scheme needs at least a few cycles per bit
  if (SYMBOL_EDGE_TIME < 4) begin : g_rate_check
    $error("uart_receiver: CLOCK_FREQ/BAUD_RATE must be at least 4");
  end

  if (STOP_BITS != 1) begin : g_stop_check
    $error("uart_receiver: only a single stop bit is supported");
  end

  logic                 w_rx_s;
  logic                 w_fire;

  uart_rx_state_t       r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [IDX_WIDTH-1:0] r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [7:0]           r_data;
  logic                 r_valid;
  logic                 r_framing_error;
  logic                 r_overrun;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (serial_in),
    .q     (w_rx_s)
  );

  assign w_fire = r_valid & data_out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_cnt           <= '0;
      r_bit_idx       <= '0;
      r_shift         <= '0;
      r_data          <= 8'h00;
      r_valid         <= 1'b0;
      r_framing_error <= 1'b0;
      r_overrun       <= 1'b0;
    end else begin
      // Error outputs are single-cycle pulses
      r_framing_error <= 1'b0;
      r_overrun       <= 1'b0;

      // Consumer handshake; a load in ST_STOP below overrides this
      if (w_fire) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (!w_rx_s) begin
            r_state <= ST_START;
            r_cnt   <= '0;
          end
        end

        ST_START: begin
          // Re-check the line half a bit in; a high level means a glitch
          if (r_cnt == C_SAMPLE_LAST) begin
            if (w_rx_s) begin
              r_state <= ST_IDLE;
            end else begin
              r_state   <= ST_DATA;
              r_cnt     <= '0;
              r_bit_idx <= '0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
          end
        end

        ST_DATA: begin
          // Counter wraps one full bit later, i.e. at the middle of each bit
          if (r_cnt == C_SYMBOL_LAST) begin
            r_cnt     <= '0;
            r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            r_bit_idx <= r_bit_idx + IDX_WIDTH'(1);
            if (r_bit_idx == C_IDX_LAST) begin
              r_state <= ST_STOP;
            end
          end else begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
          end
        end

        ST_STOP: begin
          // Leave at mid-stop-bit so a back-to-back start edge is not missed
          if (r_cnt == C_SYMBOL_LAST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            if (w_rx_s) begin
              if (!r_valid || w_fire) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_framing_error <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign data_out       = r_data;
  assign data_out_valid = r_valid;
  assign framing_error  = r_framing_error;
  assign overrun        = r_overrun;

endmodule : uart_receiver
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_receiver
//  Description : Self-checking bench for uart_receiver at 10 cycles per bit.
//                Expected bytes go into a scoreboard queue when a frame is
//                sent and are compared when the DUT hands a byte over.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

  localparam int CLOCK_FREQ = 1_000_000;
  localparam int BAUD_RATE  = 100_000;
  localparam int BIT_CYC    = CLOCK_FREQ / BAUD_RATE;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       serial_in;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       framing_error;
  logic       overrun;

  uart_receiver #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .BAUD_RATE  (BAUD_RATE)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .serial_in      (serial_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .framing_error  (framing_error),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] sb[$];

  int fe_cnt      = 0;
  int ov_cnt      = 0;
  int fire_cnt    = 0;
  int valid_cyc   = 0;
  int rise_cyc    = 0;
  int start_cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge
  initial begin : monitor
    logic prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (framing_error) fe_cnt++;
        if (overrun) ov_cnt++;
        if (data_out_valid) valid_cyc++;
        if (data_out_valid && !prev_valid) rise_cyc = cyc;
        if (data_out_valid && data_out_ready) begin
          fire_cnt++;
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_output: data_out=0x%0h, required no output", data_out);
          end else begin
            check("data_out", {24'd0, data_out}, {24'd0, sb.pop_front()});
          end
        end
      end
      prev_valid = data_out_valid;
    end
  end

  // All stimulus changes happen 1ns after a rising edge
  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    start_cyc = cyc;
    serial_in = 1'b0;
    wait_cycles(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      serial_in = d[i];
      wait_cycles(BIT_CYC);
    end
    serial_in = stop_bit;
    wait_cycles(BIT_CYC);
    serial_in = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         exp_fe;
    int         exp_out;
  } vec_t;

  vec_t vecs[6];

  int fe0, ov0, fire0, val0, lat;

  initial begin
    vecs[0] = '{data: 8'h55, stop_bit: 1'b0, exp_fe: 1, exp_out: 0};
    vecs[1] = '{data: 8'h0F, stop_bit: 1'b1, exp_fe: 0, exp_out: 1};
    vecs[2] = '{data: 8'h00, stop_bit: 1'b1, exp_fe: 0, exp_out: 1};
    vecs[3] = '{data: 8'hFF, stop_bit: 1'b1, exp_fe: 0, exp_out: 1};
    vecs[4] = '{data: 8'h01, stop_bit: 1'b1, exp_fe: 0, exp_out: 1};
    vecs[5] = '{data: 8'h80, stop_bit: 1'b0, exp_fe: 1, exp_out: 0};

    // Reset and idle
    rst_n          = 1'b0;
    serial_in      = 1'b1;
    data_out_ready = 1'b0;
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(200);
    check("reset_valid", {31'd0, data_out_valid}, 32'd0);
    check("reset_ferr", {31'd0, framing_error}, 32'd0);
    check("reset_ovr", {31'd0, overrun}, 32'd0);
    check("reset_data", {24'd0, data_out}, 32'h00);
    check("reset_no_activity", valid_cyc + fe_cnt + ov_cnt, 32'd0);

    // Single byte, latency and one-cycle valid with ready held high
    data_out_ready = 1'b1;
    val0 = valid_cyc;
    sb.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    wait_cycles(20);
    lat = rise_cyc - start_cyc;
    vectors++;
    if (lat < 97 || lat > 99) begin
      miscompares++;
      $display("FAIL latency: got %0d cycles, required 98 +/- 1", lat);
    end
    check("single_valid_cycles", valid_cyc - val0, 32'd1);
    check("single_sb_empty", sb.size(), 32'd0);

    // Table-driven frames, ready high
    foreach (vecs[i]) begin
      fe0 = fe_cnt; ov0 = ov_cnt; fire0 = fire_cnt; val0 = valid_cyc;
      if (vecs[i].exp_out != 0) sb.push_back(vecs[i].data);
      send_byte(vecs[i].data, vecs[i].stop_bit);
      wait_cycles(30);
      check("vec_ferr", fe_cnt - fe0, vecs[i].exp_fe);
      check("vec_ovr", ov_cnt - ov0, 32'd0);
      check("vec_outputs", fire_cnt - fire0, vecs[i].exp_out);
      check("vec_valid_cycles", valid_cyc - val0, vecs[i].exp_out);
      check("vec_sb_empty", sb.size(), 32'd0);
    end

    // Back-to-back frames with backpressure: second byte overruns
    data_out_ready = 1'b0;
    fe0 = fe_cnt; ov0 = ov_cnt; fire0 = fire_cnt;
    sb.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    send_byte(8'hC3, 1'b1);
    wait_cycles(20);
    check("b2b_ovr", ov_cnt - ov0, 32'd1);
    check("b2b_ferr", fe_cnt - fe0, 32'd0);
    check("b2b_valid_held", {31'd0, data_out_valid}, 32'd1);
    check("b2b_data_held", {24'd0, data_out}, 32'h3C);
    data_out_ready = 1'b1;
    wait_cycles(3);
    check("b2b_valid_cleared", {31'd0, data_out_valid}, 32'd0);
    check("b2b_fires", fire_cnt - fire0, 32'd1);
    check("b2b_sb_empty", sb.size(), 32'd0);

    // Start-bit glitch
    fe0 = fe_cnt; ov0 = ov_cnt; val0 = valid_cyc;
    serial_in = 1'b0;
    wait_cycles(3);
    serial_in = 1'b1;
    wait_cycles(150);
    check("glitch_no_valid", valid_cyc - val0, 32'd0);
    check("glitch_no_pulses", (fe_cnt - fe0) + (ov_cnt - ov0), 32'd0);

    // Async reset during bit 4 of 0xFF
    fe0 = fe_cnt; ov0 = ov_cnt; val0 = valid_cyc;
    serial_in = 1'b0;
    wait_cycles(BIT_CYC);
    serial_in = 1'b1;
    wait_cycles(4 * BIT_CYC + 5);
    #2;
    rst_n = 1'b0;
    wait_cycles(2);
    rst_n = 1'b1;
    serial_in = 1'b1;
    wait_cycles(150);
    check("midreset_no_valid", valid_cyc - val0, 32'd0);
    check("midreset_no_pulses", (fe_cnt - fe0) + (ov_cnt - ov0), 32'd0);
    check("midreset_data_cleared", {24'd0, data_out}, 32'h00);
    fire0 = fire_cnt;
    sb.push_back(8'h81);
    send_byte(8'h81, 1'b1);
    wait_cycles(30);
    check("after_reset_outputs", fire_cnt - fire0, 32'd1);
    check("final_sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_uart_receiver
`default_nettype wire

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial-to-parallel UART receiver, 8N1 format, LSB first. It is the receive-side counterpart to the on-chip UART transmitter. It sits between the off-chip serial_in pin and the memory-mapped UART/IO block. Received bytes are presented on a ready/valid output backed by a one-entry holding register. Framing errors and overruns are reported as single-cycle pulses.

Parameters:
CLOCK_FREQ, 100_000_000, system clock frequency in Hz
BAUD_RATE, 115_200, line rate in bits per second
(derived localparam) SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE, clock cycles per bit
(derived localparam) SAMPLE_TIME = SYMBOL_EDGE_TIME/2, mid-bit offset
(derived localparam) CNT_WIDTH = $clog2(SYMBOL_EDGE_TIME)+1

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
serial_in  input  1  asynchronous serial line, idles high
data_out  output  8  received byte, valid while data_out_valid=1
data_out_valid  output  1  holding register full
data_out_ready  input  1  consumer accepts; fire = valid & ready
framing_error  output  1  one-cycle pulse: stop bit sampled 0
overrun  output  1  one-cycle pulse: byte completed while holding register full

Behaviour:
- Reset (rst_n=0, async):
  - FSM=IDLE; counters=0; shift register=0.
  - data_out=8'h00; data_out_valid=0; framing_error=0; overrun=0.
  - Both synchronizer flops=1, so reset release does not produce a false start.
- Input path: serial_in passes through a 2-flop synchronizer (rx_s). No other logic sees raw serial_in.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - rx_s==0 → START; clock counter cleared to 0.
- START:
  - Counter increments each cycle.
  - At counter==SAMPLE_TIME-1, sample rx_s.
    - rx_s==1: glitch → IDLE, no output.
    - rx_s==0: → DATA; counter=0; bit index=0.
- DATA:
  - Counter counts 0..SYMBOL_EDGE_TIME-1, then wraps to 0.
  - At each wrap, shift rx_s into bit[7] of the shift register with a right shift, giving LSB-first order. Bit index then increments.
  - After 8 samples → STOP; counter=0.
- STOP:
  - At counter==SYMBOL_EDGE_TIME-1, sample rx_s, then → IDLE the next cycle. Returning to IDLE at mid-stop-bit allows back-to-back frames.
  - rx_s==1, holding register empty or firing this cycle: load data_out and set data_out_valid=1 on the next edge.
  - rx_s==1, holding register full and not firing: drop the new byte, keep data_out, pulse overrun.
  - rx_s==0: drop the byte, pulse framing_error. data_out/valid are unchanged.
- Holding register:
  - data_out_valid clears on fire.
  - A simultaneous fire and load leaves valid=1 with the new data.
  - data_out is stable while valid=1 and not fired.
- Latency: data_out_valid rises 2 + SAMPLE_TIME + 9*SYMBOL_EDGE_TIME + 1 cycles (±1) after serial_in falls for the start bit.
- Counter width: CNT_WIDTH bits; compare against the localparams only, with no truncation. SYMBOL_EDGE_TIME ≥ 4 is required; simulation-time assertion otherwise.
- Reset mid-frame: immediate return to IDLE; partial byte discarded; no pulses.

Decomposition:
- Shared package uart_pkg:
  - FSM state typedef/localparams (IDLE/START/DATA/STOP).
  - Frame constants DATA_BITS=8, STOP_BITS=1.
  - Helper function for cycles-per-bit, shared with the transmitter.
- One sub-module: sync_2ff (parameter RESET_VAL, async active-low reset), used for serial_in.

Test Plan (CLOCK_FREQ=1_000_000, BAUD_RATE=100_000 → 10 cycles/bit):
- Reset idle: hold rst_n=0 for 3 cycles, release with serial_in=1, wait 200 cycles → data_out_valid=0, framing_error=0, overrun=0, data_out=8'h00.
- Single byte: send 0xA5 (start, 1,0,1,0,0,1,0,1, stop), data_out_ready=1 → data_out_valid high for exactly 1 cycle, 98±1 cycles after the start edge, with data_out=8'hA5.
- Back-to-back with backpressure: send 0x3C then 0xC3 with no idle gap, data_out_ready=0 → first valid shows 8'h3C; second completion pulses overrun once; data_out remains 8'h3C; ready=1 then clears valid.
- Glitch rejection: pull serial_in low for 3 cycles, then high → FSM returns to IDLE; no valid and no pulses within 150 cycles.
- Framing error: send 0x55 with stop bit=0 → framing_error pulses once, data_out_valid stays 0. A following good 0x0F is received correctly.
- Async reset mid-frame: assert rst_n=0 during bit 4 of 0xFF for 2 cycles, then idle the line → no output. A subsequent 0x81 is received correctly.
